// File: rtl/fta_bus_pkg.sv
// Shared FTA bus types and constants, plus the FTA-to-Wishbone bridge state encoding.
package fta_bus_pkg;

    localparam int TID_W  = 8;
    localparam int BLEN_W = 6;
    localparam int CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_LOAD  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_STORE = 4'd2;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] ERR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBCYC = 2'd1,
        RESP  = 2'd2,
        NACK  = 2'd3
    } fta_to_wb_state_t;

    // Burst beats advance by one full data word with natural 32-bit wrap-around.
    function automatic logic [31:0] beat_adr_next(input logic [31:0] adr, input logic [31:0] step);
        return adr + step;
    endfunction

endpackage

// File: rtl/fta_bus_if.sv
// FTA request/response bundle; the requester drives req_*, the responder drives resp_*.
interface fta_bus_interface #(
    parameter int WID = 256
);
    import fta_bus_pkg::*;

    logic                  req_cyc;
    logic [CMD_W-1:0]      req_cmd;
    logic [31:0]           req_adr;
    logic [WID/8-1:0]      req_sel;
    logic [WID-1:0]        req_data1;
    logic [TID_W-1:0]      req_tid;
    logic [BLEN_W-1:0]     req_blen;

    logic                  resp_ack;
    logic [1:0]            resp_err;
    logic                  resp_rty;
    logic                  resp_stall;
    logic [TID_W-1:0]      resp_tid;
    logic [31:0]           resp_adr;
    logic [WID-1:0]        resp_dat;

    modport master (
        output req_cyc, req_cmd, req_adr, req_sel, req_data1, req_tid, req_blen,
        input  resp_ack, resp_err, resp_rty, resp_stall, resp_tid, resp_adr, resp_dat
    );

    modport slave (
        input  req_cyc, req_cmd, req_adr, req_sel, req_data1, req_tid, req_blen,
        output resp_ack, resp_err, resp_rty, resp_stall, resp_tid, resp_adr, resp_dat
    );

endinterface

// File: rtl/fta_to_wb_bridge.sv
// Single-outstanding FTA responder issuing Wishbone master cycles, with load bursts.
// Optional Wishbone timeout enabled by defining FTA_TO_WB_TIMEOUT_EN.
module fta_to_wb_bridge
    import fta_bus_pkg::*;
#(
    parameter int WID = 256,
    parameter int TMO = 1023
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cs_i,
    fta_bus_interface.slave  fta_i,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [WID/8-1:0] sel_o,
    output logic [31:0]      adr_o,
    output logic [WID-1:0]   dat_o,
    input  logic             ack_i,
    input  logic             err_i,
    input  logic [WID-1:0]   dat_i
);

    localparam logic [31:0] STEP = 32'(WID / 8);

    fta_to_wb_state_t  state_r, state_s;
    logic              cyc_r, cyc_s, we_r, we_s, is_load_r, is_load_s, last_r, last_s;
    logic [WID/8-1:0]  sel_r, sel_s;
    logic [31:0]       adr_r, adr_s, radr_r, radr_s;
    logic [WID-1:0]    dat_r, dat_s, rdat_r, rdat_s;
    logic [TID_W-1:0]  tid_r, tid_s;
    logic [BLEN_W-1:0] beats_r, beats_s;
    logic              rack_r, rack_s, rstall_r, rstall_s;
    logic [1:0]        rerr_r, rerr_s;
    logic              timeout_s;

`ifdef FTA_TO_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    assign timeout_s = (state_r == WBCYC) && (tmo_cnt_r == TMO_W'(TMO - 1));

    // Counts consecutive cycles spent waiting in one Wishbone cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_r <= '0;
        end else if (state_r == WBCYC && state_s == WBCYC) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-register values; all outputs come straight from registers.
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        we_s      = we_r;
        is_load_s = is_load_r;
        last_s    = last_r;
        sel_s     = sel_r;
        adr_s     = adr_r;
        dat_s     = dat_r;
        tid_s     = tid_r;
        beats_s   = beats_r;
        radr_s    = radr_r;
        rdat_s    = rdat_r;
        rack_s    = 1'b0;
        rerr_s    = OKAY;
        case (state_r)
            IDLE: begin
                if (fta_i.req_cyc && cs_i) begin
                    adr_s     = fta_i.req_adr;
                    sel_s     = fta_i.req_sel;
                    dat_s     = fta_i.req_data1;
                    tid_s     = fta_i.req_tid;
                    we_s      = (fta_i.req_cmd == CMD_STORE);
                    is_load_s = (fta_i.req_cmd == CMD_LOAD);
                    beats_s   = (fta_i.req_cmd == CMD_LOAD) ? fta_i.req_blen : '0;
                    last_s    = 1'b0;
                    cyc_s     = 1'b1;
                    state_s   = WBCYC;
                end else begin
                    state_s = IDLE;
                end
            end
            WBCYC: begin
                // err_i wins over ack_i; a timeout behaves like an error with no data.
                if (err_i || timeout_s) begin
                    cyc_s   = 1'b0;
                    rack_s  = 1'b1;
                    rerr_s  = ERR;
                    rdat_s  = '0;
                    radr_s  = adr_r;
                    last_s  = 1'b1;
                    state_s = RESP;
                end else if (ack_i) begin
                    cyc_s   = 1'b0;
                    rack_s  = 1'b1;
                    rdat_s  = is_load_r ? dat_i : '0;
                    radr_s  = adr_r;
                    last_s  = (beats_r == '0);
                    state_s = RESP;
                end else begin
                    state_s = WBCYC;
                end
            end
            RESP: begin
                if (!last_r) begin
                    adr_s   = beat_adr_next(adr_r, STEP);
                    beats_s = beats_r - BLEN_W'(1);
                    cyc_s   = 1'b1;
                    state_s = WBCYC;
                end else begin
                    state_s = NACK;
                end
            end
            NACK: begin
                state_s = IDLE;
            end
            default: begin
                cyc_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
        rstall_s = (state_s != IDLE);
    end

    // State and datapath registers; reset abandons any cycle without a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            is_load_r <= 1'b0;
            last_r    <= 1'b0;
            sel_r     <= '0;
            adr_r     <= 32'h0;
            dat_r     <= '0;
            tid_r     <= '0;
            beats_r   <= '0;
            radr_r    <= 32'h0;
            rdat_r    <= '0;
            rack_r    <= 1'b0;
            rerr_r    <= OKAY;
            rstall_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            we_r      <= we_s;
            is_load_r <= is_load_s;
            last_r    <= last_s;
            sel_r     <= sel_s;
            adr_r     <= adr_s;
            dat_r     <= dat_s;
            tid_r     <= tid_s;
            beats_r   <= beats_s;
            radr_r    <= radr_s;
            rdat_r    <= rdat_s;
            rack_r    <= rack_s;
            rerr_r    <= rerr_s;
            rstall_r  <= rstall_s;
        end
    end

    assign cyc_o = cyc_r;
    assign stb_o = cyc_r;
    assign we_o  = we_r;
    assign sel_o = sel_r;
    assign adr_o = adr_r;
    assign dat_o = dat_r;

    assign fta_i.resp_ack   = rack_r;
    assign fta_i.resp_err   = rerr_r;
    assign fta_i.resp_rty   = 1'b0;
    assign fta_i.resp_stall = rstall_r;
    assign fta_i.resp_tid   = tid_r;
    assign fta_i.resp_adr   = radr_r;
    assign fta_i.resp_dat   = rdat_r;

endmodule

// File: tb/tb_fta_to_wb_bridge.sv
// Randomized bench for fta_to_wb_bridge: a transaction-level model predicts the Wishbone
// beats and FTA responses; one negedge process plays the slave and compares every cycle.
module tb_fta_to_wb_bridge;
    import fta_bus_pkg::*;

    localparam int WID = 256;
    localparam int SW  = WID / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs = 1'b0;
    logic wb_ack = 1'b0;
    logic wb_err = 1'b0;
    logic [WID-1:0] dat_in = '0;
    logic cyc, stb, we;
    logic [SW-1:0] sel;
    logic [31:0] adr;
    logic [WID-1:0] dat_out;

    fta_bus_interface #(.WID(WID)) bus ();

    fta_to_wb_bridge #(.WID(WID), .TMO(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cs_i(cs), .fta_i(bus),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .sel_o(sel), .adr_o(adr), .dat_o(dat_out),
        .ack_i(wb_ack), .err_i(wb_err), .dat_i(dat_in)
    );

    always #5 clk = ~clk;

    // kind: 0 ack, 1 err, 2 ack+err together, 3 silent slave
    typedef struct {
        logic [31:0] adr; logic we; logic [SW-1:0] sel;
        logic [WID-1:0] wdat; logic [WID-1:0] rdat; int lat; int kind;
    } beat_t;
    typedef struct {
        logic [7:0] tid; logic [31:0] adr; logic [WID-1:0] dat; logic [1:0] err;
    } rsp_t;

    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];
    logic [31:0] seen_adr[$];
    int errors = 0;
    int checks = 0;
    int cur_len = 0;
    int last_len = 0;
    int wait_cnt = 0;
    logic last_we = 1'b0;
    logic [SW-1:0] last_sel = '0;
    logic [WID-1:0] last_rdat = '0;
    logic [1:0] last_rerr = OKAY;

    task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [WID-1:0] rand_wide();
        logic [WID-1:0] v;
        for (int i = 0; i < WID / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [WID-1:0] slave_data(input logic [31:0] a);
        return {(WID/32){a ^ 32'hC0DE0000}};
    endfunction

    // Slave model and per-cycle comparator.
    always @(negedge clk) begin
        beat_t b;
        rsp_t r;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        chk("resp_rty", {255'b0, bus.resp_rty}, '0);
        if (!rst_n) begin
            chk("rst_cyc", {255'b0, cyc}, '0);
            chk("rst_stb", {255'b0, stb}, '0);
            chk("rst_we", {255'b0, we}, '0);
            chk("rst_adr", {224'b0, adr}, '0);
            chk("rst_sel", {224'b0, sel}, '0);
            chk("rst_dat", dat_out, '0);
            chk("rst_resp_ack", {255'b0, bus.resp_ack}, '0);
            chk("rst_resp_stall", {255'b0, bus.resp_stall}, '0);
            chk("rst_resp_err", {254'b0, bus.resp_err}, {254'b0, OKAY});
            chk("rst_resp_dat", bus.resp_dat, '0);
            wait_cnt = 0;
            cur_len = 0;
        end else begin
            if (bus.resp_ack) begin
                chk("resp_stall_busy", {255'b0, bus.resp_stall}, {255'b0, 1'b1});
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got ack tid=%0h want none at %0t", bus.resp_tid, $time);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("resp_tid", {248'b0, bus.resp_tid}, {248'b0, r.tid});
                    chk("resp_adr", {224'b0, bus.resp_adr}, {224'b0, r.adr});
                    chk("resp_dat", bus.resp_dat, r.dat);
                    chk("resp_err", {254'b0, bus.resp_err}, {254'b0, r.err});
                    last_rdat = bus.resp_dat;
                    last_rerr = bus.resp_err;
                end
            end else begin
                chk("resp_err_idle", {254'b0, bus.resp_err}, {254'b0, OKAY});
            end
            if (cyc) begin
                cur_len++;
                chk("stb", {255'b0, stb}, {255'b0, 1'b1});
                chk("stall_in_cyc", {255'b0, bus.resp_stall}, {255'b0, 1'b1});
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cycle: got cyc adr=%0h want idle at %0t", adr, $time);
                end else begin
                    b = exp_beats[0];
                    chk("wb_adr", {224'b0, adr}, {224'b0, b.adr});
                    chk("wb_we", {255'b0, we}, {255'b0, b.we});
                    chk("wb_sel", {224'b0, sel}, {224'b0, b.sel});
                    chk("wb_dat", dat_out, b.wdat);
                    if (b.kind != 3 && wait_cnt == b.lat) begin
                        wb_ack = (b.kind == 0 || b.kind == 2);
                        wb_err = (b.kind == 1 || b.kind == 2);
                        dat_in = b.rdat;
                        seen_adr.push_back(b.adr);
                        last_we = we;
                        last_sel = sel;
                        void'(exp_beats.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                if (cur_len != 0) last_len = cur_len;
                cur_len = 0;
                wait_cnt = 0;
            end
        end
    end

    // One FTA request: predict beats/responses from the request, drive it, wait for completion.
    task automatic do_txn(input logic [3:0] cmd, input logic [31:0] base, input logic [SW-1:0] s,
                          input logic [WID-1:0] d1, input logic [7:0] tid, input logic [5:0] blen,
                          input int lat, input int err_at, input int err_kind, input bit use_cs);
        int n;
        int budget;
        bit silent;
        beat_t b;
        rsp_t r;
        n = (cmd == CMD_LOAD) ? int'(blen) + 1 : 1;
        silent = 1'b0;
        if (use_cs) begin
            for (int i = 0; i < n; i++) begin
                b.adr = base + 32'(i * SW);
                b.we = (cmd == CMD_STORE);
                b.sel = s;
                b.wdat = d1;
                b.rdat = slave_data(b.adr);
                b.lat = lat;
                b.kind = (i == err_at) ? err_kind : 0;
                exp_beats.push_back(b);
                r.tid = tid;
                r.adr = b.adr;
                r.dat = (b.kind != 0 || cmd != CMD_LOAD) ? '0 : b.rdat;
                r.err = (b.kind != 0) ? ERR : OKAY;
                exp_rsp.push_back(r);
                if (b.kind == 3) silent = 1'b1;
                if (b.kind != 0) break;
            end
        end
        @(negedge clk); #2;
        chk("stall_before_req", {255'b0, bus.resp_stall}, '0);
        bus.req_cyc = 1'b1; bus.req_cmd = cmd; bus.req_adr = base; bus.req_sel = s;
        bus.req_data1 = d1; bus.req_tid = tid; bus.req_blen = blen; cs = use_cs;
        @(negedge clk); #2;
        bus.req_cyc = 1'b0; cs = 1'b0;
        if (use_cs) begin
            budget = 0;
            while (exp_rsp.size() != 0 && budget < 400) begin
                @(negedge clk); #2;
                budget++;
            end
            if (budget >= 400) begin
                checks++; errors++;
                $display("FAIL txn_timeout: got %0d responses pending want 0", exp_rsp.size());
                exp_rsp.delete();
            end
            if (silent) exp_beats.delete();
            chk("beats_done", 256'(exp_beats.size()), '0);
            exp_beats.delete();
            @(negedge clk); #2;
            chk("nack_stall", {255'b0, bus.resp_stall}, {255'b0, 1'b1});
            chk("nack_cyc", {255'b0, cyc}, '0);
            @(negedge clk); #2;
            chk("idle_stall", {255'b0, bus.resp_stall}, '0);
            chk("idle_cyc", {255'b0, cyc}, '0);
        end else begin
            repeat (4) @(negedge clk);
            #2;
            chk("ignored_stall", {255'b0, bus.resp_stall}, '0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [5:0] bl;
        int ea;
        bus.req_cyc = 1'b0; bus.req_cmd = '0; bus.req_adr = '0; bus.req_sel = '0;
        bus.req_data1 = '0; bus.req_tid = '0; bus.req_blen = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single load, slave acks after 2 wait cycles
        do_txn(CMD_LOAD, 32'h0000_1000, '1, '0, 8'h5A, 6'd0, 2, -1, 0, 1'b1);
        chk("pin_load_len", 256'(last_len), 256'd3);
        chk("pin_load_dat", last_rdat, {(WID/32){32'hC0DE_1000}});
        chk("pin_load_err", {254'b0, last_rerr}, {254'b0, OKAY});

        // Single store with narrow byte select
        do_txn(CMD_STORE, 32'h0000_2000, 32'h0000_000F, {(WID/32){32'hA5A5_A5A5}}, 8'h11, 6'd2, 1, -1, 0, 1'b1);
        chk("pin_store_we", {255'b0, last_we}, {255'b0, 1'b1});
        chk("pin_store_sel", {224'b0, last_sel}, {224'b0, 32'h0000_000F});
        chk("pin_store_dat", last_rdat, '0);

        // Four-beat load burst
        seen_adr.delete();
        do_txn(CMD_LOAD, 32'h0000_3000, '1, '0, 8'h22, 6'd3, 0, -1, 0, 1'b1);
        chk("pin_burst_n", 256'(seen_adr.size()), 256'd4);
        if (seen_adr.size() == 4) begin
            chk("pin_burst_a1", {224'b0, seen_adr[1]}, {224'b0, 32'h0000_3020});
            chk("pin_burst_a3", {224'b0, seen_adr[3]}, {224'b0, 32'h0000_3060});
        end

        // Address wrap on the second beat
        seen_adr.delete();
        do_txn(CMD_LOAD, 32'hFFFF_FFE0, '1, '0, 8'h33, 6'd1, 1, -1, 0, 1'b1);
        chk("pin_wrap_n", 256'(seen_adr.size()), 256'd2);
        if (seen_adr.size() == 2) chk("pin_wrap_a1", {224'b0, seen_adr[1]}, '0);

        // ack and err together on beat 0 ends the burst with ERR
        seen_adr.delete();
        do_txn(CMD_LOAD, 32'h0000_4000, '1, '0, 8'h44, 6'd2, 1, 0, 2, 1'b1);
        chk("pin_err_n", 256'(seen_adr.size()), 256'd1);
        chk("pin_err_code", {254'b0, last_rerr}, {254'b0, ERR});

        // Request ignored when cs_i is low
        do_txn(CMD_LOAD, 32'h0000_5000, '1, '0, 8'h55, 6'd0, 0, -1, 0, 1'b0);

`ifdef FTA_TO_WB_TIMEOUT_EN
        // Silent slave: cycle must end after TMO cycles with ERR and zero data
        do_txn(CMD_LOAD, 32'h0000_6000, '1, '0, 8'h66, 6'd0, 0, 0, 3, 1'b1);
        chk("pin_tmo_len", 256'(last_len), 256'(TMO));
        chk("pin_tmo_err", {254'b0, last_rerr}, {254'b0, ERR});
        chk("pin_tmo_dat", last_rdat, '0);
`endif

        // Reset in the middle of a Wishbone cycle: abandon it, no response
        begin
            beat_t b;
            b.adr = 32'h0000_7000; b.we = 1'b0; b.sel = '1; b.wdat = '0;
            b.rdat = '0; b.lat = 0; b.kind = 3;
            exp_beats.push_back(b);
            @(negedge clk); #2;
            bus.req_cyc = 1'b1; bus.req_cmd = CMD_LOAD; bus.req_adr = b.adr; bus.req_sel = '1;
            bus.req_data1 = '0; bus.req_tid = 8'h77; bus.req_blen = 6'd0; cs = 1'b1;
            @(negedge clk); #2;
            bus.req_cyc = 1'b0; cs = 1'b0;
            repeat (2) @(negedge clk);
            #2;
            chk("pre_rst_cyc", {255'b0, cyc}, {255'b0, 1'b1});
            rst_n = 1'b0;
            #1;
            chk("rst_async_cyc", {255'b0, cyc}, '0);
            chk("rst_async_stb", {255'b0, stb}, '0);
            chk("rst_async_adr", {224'b0, adr}, '0);
            exp_beats.delete();
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (4) @(negedge clk);
            #2;
            chk("post_rst_stall", {255'b0, bus.resp_stall}, '0);
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            a = $urandom();
            a[4:0] = 5'b0;
            bl = 6'($urandom_range(0, 3));
            ea = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, bl)) : -1;
            do_txn(($urandom_range(0, 1) == 0) ? CMD_LOAD : CMD_STORE, a, SW'($urandom()),
                   rand_wide(), 8'($urandom()), bl, int'($urandom_range(0, 4)), ea,
                   int'($urandom_range(1, 2)), ($urandom_range(0, 7) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fta_to_wb_bridge.md
FTA_TO_WB_BRIDGE -- requirements
Module: fta_to_wb_bridge

Interface
REQ-001 SHALL have parameter WID, default 256, giving the data width in bits for both the FTA and Wishbone sides.
REQ-002 SHALL have parameter TMO, default 1023, giving the Wishbone cycle-timeout limit in clk_i cycles.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock; rst_ni  input  1  reset.
REQ-004 SHALL have port cs_i  input  1  FTA-side select; a request is taken only when cs_i is high.
REQ-005 SHALL have port fta_i  fta_bus_interface.slave  --  FTA responder port, consuming req and driving resp.
REQ-006 SHALL have ports cyc_o, stb_o, we_o  output  1 each  Wishbone master cycle, strobe and write enable.
REQ-007 SHALL have ports sel_o  output  WID/8  byte selects; adr_o  output  32  address; dat_o  output  WID  write data.
REQ-008 SHALL have ports ack_i, err_i  input  1 each  Wishbone acknowledge and error; dat_i  input  WID  read data.

Function
REQ-009 SHALL implement states IDLE, WBCYC, RESP and NACK, using the fta_to_wb_state_t encoding.
REQ-010 SHALL, in IDLE with req.cyc and cs_i high, latch req.adr, sel, we, data1, tid and blen in one cycle and go to WBCYC.
REQ-011 SHALL drive resp.stall high in every state except IDLE, so that at most one request is outstanding.
REQ-012 SHALL, in WBCYC, hold cyc_o=stb_o=1 with the latched we, sel, adr and data until ack_i, err_i or the timeout occurs.
REQ-013 SHALL, on ack_i in WBCYC, drop cyc_o and stb_o in the next cycle, capture dat_i (loads only) and go to RESP.
REQ-014 SHALL, in RESP, present resp.ack=1 for exactly one cycle with the captured data, the echoed tid, resp.adr equal to the beat address, and resp.err=OKAY.
REQ-015 SHALL treat a load with blen=N as N+1 beats: after each RESP, while beats remain, add WID/8 to adr_o with 32-bit wrap-around and return to WBCYC.
REQ-016 SHALL execute a store as a single beat regardless of blen.
REQ-017 SHALL, on err_i in WBCYC, end the burst after that beat with resp.ack=1 and resp.err=ERR.
REQ-018 SHALL, after the final beat, pass through NACK for one cycle with stall still high before returning to IDLE, guaranteeing a one-cycle cyc_o gap between requests.
REQ-019 SHALL prioritise err_i over ack_i when both are asserted in the same cycle.
REQ-020 SHALL keep resp.rty at 0 at all times.
REQ-021 SHALL drive resp.ack and resp.err to their idle values (0 and OKAY) in every cycle other than RESP.

Reset
REQ-022 SHALL, on rst_ni low and independently of clk_i, force state=IDLE and drive cyc_o, stb_o and we_o to 0.
REQ-023 SHALL, on reset, drive sel_o, adr_o and dat_o to 0, clear the beat and timeout counters, and zero all resp fields (err=OKAY, stall=0).
REQ-024 SHALL, if reset is asserted mid-cycle, abandon the cycle without producing an FTA response.

Configuration
REQ-025 SHALL, when FTA_TO_WB_TIMEOUT_EN is defined, count cycles in WBCYC and, on reaching TMO without ack_i or err_i, drop cyc_o and respond with resp.ack=1, resp.err=ERR and dat=0.
REQ-026 SHALL, when FTA_TO_WB_TIMEOUT_EN is undefined, contain no timeout counter and wait in WBCYC indefinitely.

Structure
REQ-027 SHALL place the fta_to_wb_state_t enum in fta_bus_pkg and use the existing fta_bus_pkg constants OKAY, ERR, CMD_LOAD and CMD_STORE.
REQ-028 SHALL be a single module with no sub-modules; the timeout counter stays inline.

Verification
REQ-029 SHALL pass: single load at adr 0x1000 with a slave acking after 2 cycles -> one resp.ack carrying the slave data, the echoed tid, err=OKAY, and stall high from capture until NACK ends.
REQ-030 SHALL pass: store of data1=0xA5.. with sel=0x0000000F at 0x2000 -> one WB cycle with we_o=1 and sel_o=0x0000000F, one resp.ack.
REQ-031 SHALL pass: load with blen=3 at 0x3000 -> four WB cycles at 0x3000, 0x3020, 0x3040 and 0x3060, giving four resp.acks in order.
REQ-032 SHALL pass: load with blen=1 at 0xFFFFFFE0 -> second beat at 0x00000000.
REQ-033 SHALL pass: ack_i and err_i asserted together on beat 0 of a blen=2 load -> a single resp.ack with err=ERR, no further WB cycles.
REQ-034 SHALL pass: with FTA_TO_WB_TIMEOUT_EN and TMO=8 and a silent slave -> cyc_o drops after 8 cycles and resp.err=ERR; a reset pulse mid-cycle -> cyc_o=0 at once and no resp.ack.
